pktd_fifo_ctrl: RTL and testbench
=================================

Name: pktd_fifo_ctrl

Overview:
- Packet-mode FIFO controller that owns the packet-data memory (MEMIF_PKTD, f0_* signals) and drives its write and read ports.
- Sits between the MAC TX ingress (producer) and the TX framer (consumer).
- Store-and-forward operation: the consumer sees a packet only after its last word has been written.
- Supports writer abort and automatic drop of oversized packets.

Parameters:
- DWIDTH, 32: data word width; matches the memory.
- AWIDTH, 32: memory address port width.
- FIFO_AW, 10: log2 of FIFO depth in words (DEPTH = 1<<FIFO_AW).
- BASE_ADDR, 0: memory word address of FIFO slot 0.
- PKT_AW, 4: log2 of the committed-packet length queue depth (PKT_DEPTH = 1<<PKT_AW).

Ports:
- clk  in  1  clock; the memory write port uses the same clock.
- resetn  in  1  asynchronous active-low reset.
- wr_valid  in  1  producer word valid.
- wr_ready  out  1  controller can accept a word.
- wr_data  in  DWIDTH  producer word.
- wr_last  in  1  final word of the packet.
- wr_abort  in  1  single-cycle pulse: discard the packet in progress.
- rd_valid  out  1  output word valid.
- rd_ready  in  1  consumer accepts the word.
- rd_data  out  DWIDTH  output word.
- rd_last  out  1  final word of the packet.
- f0_waddr  out  AWIDTH  memory write address.
- f0_wdata  out  DWIDTH  memory write data.
- f0_write  out  1  memory write enable.
- f0_raddr  out  AWIDTH  memory read address.
- f0_rdata  in  DWIDTH  memory read data (combinational with f0_raddr).
- pkt_count  out  PKT_AW+1  number of committed packets not yet fully read.
- ovf_drop  out  1  one-cycle pulse when an oversized packet is auto-dropped.

Behaviour:
- Reset values (async, resetn=0):
  - All pointers, length counter and packet queue are 0.
  - Read FSM is IDLE.
  - wr_ready=0 during reset, 1 from the first clock after release.
  - rd_valid=0, rd_last=0, f0_write=0, f0_waddr=BASE_ADDR, f0_raddr=BASE_ADDR, pkt_count=0, ovf_drop=0.
- Pointers: wr_ptr (speculative), cm_ptr (committed) and rd_ptr, each FIFO_AW+1 bits with a wrap bit.
  - used = wr_ptr-rd_ptr (mod 2^(FIFO_AW+1)).
  - full when used==DEPTH.
- wr_ready = !full && pkt_count<PKT_DEPTH.
- Write accept (wr_valid&&wr_ready&&!wr_abort), combinational to memory:
  - f0_write=1, f0_waddr=BASE_ADDR+wr_ptr[FIFO_AW-1:0], f0_wdata=wr_data.
  - Memory captures on the same clk edge; wr_ptr++ and cur_len++.
- Commit: on an accepted word with wr_last=1:
  - Push cur_len+1 onto the length queue; cm_ptr<=wr_ptr+1; cur_len<=0.
  - A single-word packet is legal and commits a length of 1.
- Abort: wr_abort=1 sets wr_ptr<=cm_ptr and cur_len<=0.
  - A word presented in the same cycle is not written (f0_write=0), even with wr_last.
  - Abort with no packet in progress has no effect.
- Oversize drop: full && cm_ptr==rd_ptr && cur_len>0 means the packet exceeds DEPTH.
  - Apply the same rewind as abort and pulse ovf_drop for 1 cycle.
  - The writer's remaining words up to and including wr_last are then discarded (wr_ready=1, no writes, no commit).
- Read FSM:
  - IDLE: rd_valid=0. When the queue is non-empty, load rem<=queue head and go to ACTIVE (1 cycle latency from commit to rd_valid).
  - ACTIVE: rd_valid=1, f0_raddr=BASE_ADDR+rd_ptr[FIFO_AW-1:0], rd_data=f0_rdata, rd_last=(rem==1).
  - On rd_valid&&rd_ready: rd_ptr++ and rem--.
  - If rd_last is accepted, pop the queue. If another packet is committed, reload rem directly and stay in ACTIVE (back-to-back, no bubble); otherwise go to IDLE.
  - rd_data and rd_last stay stable while rd_valid&&!rd_ready.
- Reads only ever see committed words (rd_ptr never passes cm_ptr), so abort/drop never affects the read side.
- pkt_count: +1 on commit, -1 on pop; both in one cycle leaves it unchanged.
- Simultaneous write and read in the full or near-full state is legal; full is evaluated on registered pointers (no same-cycle fall-through).
- Address wrap: slot index wraps at DEPTH; the wrap bit toggles.

Test Plan:
- Single packet: after reset, push 4 words 0xA0..0xA3 with last on 0xA3 -> f0_write on 4 consecutive cycles, addresses BASE+0..3; rd_valid rises 1 cycle after commit; consumer reads 0xA0..0xA3, rd_last only on 0xA3; pkt_count 1->0.
- Back-to-back: commit packets of 3 and 1 words, rd_ready held 1 -> 4 contiguous rd_valid cycles, rd_last on word 3 and word 4, no bubble.
- Abort: push 0x10,0x11, then wr_abort with wr_valid=1 and data 0x12 -> f0_write=0 that cycle; next packet 0x20 (last) is written at BASE+0 and read back as a 1-word packet.
- Full/wrap: FIFO_AW=2, write 2-word packets repeatedly while rd_ready toggles 1,0 -> wr_ready drops exactly at used==4; addresses wrap 3->0; read data order is preserved.
- Oversize: FIFO_AW=2, 6-word packet with consumer idle -> ovf_drop pulses once at the 4th word; pkt_count stays 0; a following 2-word packet reads correctly.
- Reset mid-packet: assert resetn=0 while ACTIVE with rd_ready=0 -> rd_valid=0 and pkt_count=0 immediately (async); no reads after release.

Source files
------------

// File: rtl/pktd_fifo_ctrl.sv
// rtl/pktd_fifo_ctrl.sv - packet-mode store-and-forward FIFO controller
// Owns the packet-data memory ports; reader only ever sees fully committed packets.
module pktd_fifo_ctrl #(
   parameter int                DWIDTH    = 32,
   parameter int                AWIDTH    = 32,
   parameter int                FIFO_AW   = 10,
   parameter logic [AWIDTH-1:0] BASE_ADDR = '0,
   parameter int                PKT_AW    = 4
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                wr_valid,
   output logic                wr_ready,
   input  logic [DWIDTH-1:0]   wr_data,
   input  logic                wr_last,
   input  logic                wr_abort,
   output logic                rd_valid,
   input  logic                rd_ready,
   output logic [DWIDTH-1:0]   rd_data,
   output logic                rd_last,
   output logic [AWIDTH-1:0]   f0_waddr,
   output logic [DWIDTH-1:0]   f0_wdata,
   output logic                f0_write,
   output logic [AWIDTH-1:0]   f0_raddr,
   input  logic [DWIDTH-1:0]   f0_rdata,
   output logic [PKT_AW:0]     pkt_count,
   output logic                ovf_drop
);

   localparam int PW        = FIFO_AW + 1;
   localparam int PKT_DEPTH = 1 << PKT_AW;
   localparam logic [PW-1:0]   DEPTH_V = {1'b1, {FIFO_AW{1'b0}}};
   localparam logic [PKT_AW:0] PKT_V   = {1'b1, {PKT_AW{1'b0}}};

   typedef enum logic {RD_IDLE, RD_ACTIVE} rd_state_e;

   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     cm_ptr_q, cm_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]     cur_len_q, cur_len_d;
   logic [PW-1:0]     rem_q, rem_d;
   logic [PKT_AW:0]   q_wr_q, q_wr_d;
   logic [PKT_AW:0]   q_rd_q, q_rd_d;
   logic [PW-1:0]     len_mem_q [PKT_DEPTH];
   logic              drop_q, drop_d;
   logic              init_q;
   rd_state_e         state_q, state_d;

   logic [PW-1:0]     used;
   logic              full;
   logic              wr_acc;
   logic              wr_fire;
   logic              commit;
   logic              rd_fire;
   logic              pop;
   logic [PKT_AW-1:0] q_head_idx;
   logic [PKT_AW-1:0] q_next_idx;

   assign used       = wr_ptr_q - rd_ptr_q;
   assign full       = (used == DEPTH_V);
   assign pkt_count  = q_wr_q - q_rd_q;
   assign q_head_idx = q_rd_q[PKT_AW-1:0];
   assign q_next_idx = q_rd_q[PKT_AW-1:0] + PKT_AW'(1);

   // Only speculative words fill the FIFO and nothing can drain: packet exceeds DEPTH.
   assign ovf_drop = full && (cm_ptr_q == rd_ptr_q) && (cur_len_q != '0);

   // While discarding an oversized tail the writer is drained without writing.
   assign wr_ready = init_q && (drop_q || (!full && (pkt_count != PKT_V)));
   assign wr_acc   = wr_valid && wr_ready && !wr_abort;
   assign wr_fire  = wr_acc && !drop_q;
   assign commit   = wr_fire && wr_last;

   assign f0_write = wr_fire;
   assign f0_wdata = wr_data;
   assign f0_waddr = BASE_ADDR + AWIDTH'(wr_ptr_q[FIFO_AW-1:0]);
   assign f0_raddr = BASE_ADDR + AWIDTH'(rd_ptr_q[FIFO_AW-1:0]);

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      cm_ptr_d  = cm_ptr_q;
      cur_len_d = cur_len_q;
      drop_d    = drop_q;
      q_wr_d    = q_wr_q;
      if (wr_abort) begin
         wr_ptr_d  = cm_ptr_q;
         cur_len_d = '0;
         drop_d    = 1'b0;
      end else if (ovf_drop) begin
         wr_ptr_d  = cm_ptr_q;
         cur_len_d = '0;
         drop_d    = 1'b1;
      end else if (wr_acc) begin
         if (drop_q) begin
            if (wr_last) begin
               drop_d = 1'b0;
            end
         end else begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (wr_last) begin
               cm_ptr_d  = wr_ptr_q + PW'(1);
               cur_len_d = '0;
               q_wr_d    = q_wr_q + (PKT_AW+1)'(1);
            end else begin
               cur_len_d = cur_len_q + PW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q  <= '0;
         cm_ptr_q  <= '0;
         cur_len_q <= '0;
         drop_q    <= 1'b0;
         q_wr_q    <= '0;
         init_q    <= 1'b0;
         for (int i = 0; i < PKT_DEPTH; i++) begin
            len_mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         cm_ptr_q  <= cm_ptr_d;
         cur_len_q <= cur_len_d;
         drop_q    <= drop_d;
         q_wr_q    <= q_wr_d;
         init_q    <= 1'b1;
         if (commit) begin
            len_mem_q[q_wr_q[PKT_AW-1:0]] <= cur_len_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= RD_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RD_IDLE: begin
            if (pkt_count != '0) begin
               state_d = RD_ACTIVE;
            end
         end
         RD_ACTIVE: begin
            if (pop && (pkt_count == (PKT_AW+1)'(1))) begin
               state_d = RD_IDLE;
            end
         end
         default: state_d = RD_IDLE;
      endcase
   end

   always_comb begin
      rd_valid = 1'b0;
      rd_last  = 1'b0;
      rd_data  = '0;
      if (state_q == RD_ACTIVE) begin
         rd_valid = 1'b1;
         rd_last  = (rem_q == PW'(1));
         rd_data  = f0_rdata;
      end
   end

   assign rd_fire = rd_valid && rd_ready;
   assign pop     = rd_fire && rd_last;

   // On the final word the next committed length is loaded directly, avoiding a bubble.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      rem_d    = rem_q;
      q_rd_d   = q_rd_q;
      if (state_q == RD_IDLE) begin
         if (pkt_count != '0) begin
            rem_d = len_mem_q[q_head_idx];
         end
      end else if (rd_fire) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
         if (rd_last) begin
            q_rd_d = q_rd_q + (PKT_AW+1)'(1);
            rem_d  = len_mem_q[q_next_idx];
         end else begin
            rem_d = rem_q - PW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_ptr_q <= '0;
         rem_q    <= '0;
         q_rd_q   <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         rem_q    <= rem_d;
         q_rd_q   <= q_rd_d;
      end
   end

endmodule

// File: tb/tb_pktd_fifo_ctrl.sv
// tb/tb_pktd_fifo_ctrl.sv - randomized bench for pktd_fifo_ctrl with a transaction model
// Model tracks word/packet counts as plain integers and expected words in queues.
module tb_pktd_fifo_ctrl;

   localparam int DW        = 32;
   localparam int AW        = 32;
   localparam int FAW       = 2;
   localparam int PAW       = 2;
   localparam int DEPTH     = 1 << FAW;
   localparam int PKT_DEPTH = 1 << PAW;
   localparam logic [AW-1:0] BASE = 32'h0000_0100;

   logic          clk;
   logic          resetn;
   logic          wr_valid;
   logic          wr_ready;
   logic [DW-1:0] wr_data;
   logic          wr_last;
   logic          wr_abort;
   logic          rd_valid;
   logic          rd_ready;
   logic [DW-1:0] rd_data;
   logic          rd_last;
   logic [AW-1:0] f0_waddr;
   logic [DW-1:0] f0_wdata;
   logic          f0_write;
   logic [AW-1:0] f0_raddr;
   logic [DW-1:0] f0_rdata;
   logic [PAW:0]  pkt_count;
   logic          ovf_drop;

   logic [DW-1:0] mem [DEPTH];

   int n_vec;
   int n_miss;

   int  wm, cm, rm, cur, pkts;
   bit  drop_m, rv, init_m, last_acc, tog_rd;
   int  ovf_dut;
   logic [DW-1:0] spec_w [$];
   logic [DW-1:0] exp_d [$];
   bit            exp_l [$];

   pktd_fifo_ctrl #(
      .DWIDTH(DW), .AWIDTH(AW), .FIFO_AW(FAW), .BASE_ADDR(BASE), .PKT_AW(PAW)
   ) dut (
      .clk(clk), .resetn(resetn),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .wr_last(wr_last), .wr_abort(wr_abort),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
      .f0_waddr(f0_waddr), .f0_wdata(f0_wdata), .f0_write(f0_write),
      .f0_raddr(f0_raddr), .f0_rdata(f0_rdata),
      .pkt_count(pkt_count), .ovf_drop(ovf_drop)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      if (f0_write) mem[f0_waddr[FAW-1:0]] <= f0_wdata;
   end
   assign f0_rdata = mem[f0_raddr[FAW-1:0]];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      wm = 0; cm = 0; rm = 0; cur = 0; pkts = 0;
      drop_m = 0; rv = 0; init_m = 0; last_acc = 0;
      spec_w.delete(); exp_d.delete(); exp_l.delete();
   endtask

   // Called at posedge+1; asserts reset asynchronously and checks outputs before any edge.
   task automatic do_reset();
      wr_valid = 0; wr_last = 0; wr_abort = 0; wr_data = '0; tog_rd = 0;
      resetn = 1'b0;
      #1;
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_last", rd_last, 0);
      chk("rst_f0_write", f0_write, 0);
      chk("rst_f0_waddr", f0_waddr, BASE);
      chk("rst_f0_raddr", f0_raddr, BASE);
      chk("rst_pkt_count", pkt_count, 0);
      chk("rst_ovf_drop", ovf_drop, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      model_clear();
      resetn = 1'b1;
   endtask

   task automatic tick();
      bit full, exp_rdy, ovf, acc, wfire, rfire, pop, rv_n, lst;
      if (tog_rd) rd_ready = ~rd_ready;
      @(negedge clk);
      full    = (wm - rm) == DEPTH;
      exp_rdy = init_m && (drop_m || (!full && pkts < PKT_DEPTH));
      ovf     = full && (cm == rm) && (cur > 0);
      acc     = wr_valid && exp_rdy && !wr_abort;
      wfire   = acc && !drop_m;
      chk("wr_ready", wr_ready, exp_rdy);
      chk("f0_write", f0_write, wfire);
      if (wfire) begin
         chk("f0_waddr", f0_waddr, BASE + AW'(wm % DEPTH));
         chk("f0_wdata", f0_wdata, wr_data);
      end
      chk("ovf_drop", ovf_drop, ovf);
      chk("pkt_count", pkt_count, pkts);
      chk("rd_valid", rd_valid, rv);
      ovf_dut += int'(ovf_drop);
      lst = 0;
      if (rv && exp_d.size() > 0) begin
         chk("rd_data", rd_data, exp_d[0]);
         chk("rd_last", rd_last, exp_l[0]);
         lst = exp_l[0];
      end
      rfire = rv && rd_ready;
      pop   = rfire && lst;
      if (rfire && exp_d.size() > 0) begin
         void'(exp_d.pop_front());
         void'(exp_l.pop_front());
      end
      rv_n = !rv ? (pkts > 0) : (pop ? (pkts > 1) : 1'b1);
      rm   += int'(rfire);
      pkts -= int'(pop);
      if (wr_abort) begin
         wm = cm; cur = 0; drop_m = 0; spec_w.delete();
      end else if (ovf) begin
         wm = cm; cur = 0; drop_m = 1; spec_w.delete();
      end else if (acc) begin
         if (drop_m) begin
            if (wr_last) drop_m = 0;
         end else begin
            wm++; cur++;
            spec_w.push_back(wr_data);
            if (wr_last) begin
               foreach (spec_w[i]) begin
                  exp_d.push_back(spec_w[i]);
                  exp_l.push_back(i == spec_w.size() - 1);
               end
               spec_w.delete();
               cm = wm; cur = 0; pkts++;
            end
         end
      end
      rv = rv_n;
      last_acc = acc;
      @(posedge clk);
      #1;
      init_m = 1;
   endtask

   task automatic wr_word(input logic [DW-1:0] d, input bit l);
      int n;
      n = 0;
      wr_valid = 1; wr_data = d; wr_last = l;
      do begin
         tick();
         n++;
      end while (!last_acc && n < 60);
      if (!last_acc) chk("wr_timeout", 0, 1);
      wr_valid = 0; wr_last = 0;
   endtask

   initial begin
      n_vec = 0; n_miss = 0; ovf_dut = 0;
      resetn = 1'b0; rd_ready = 0; wr_valid = 0; wr_last = 0; wr_abort = 0; wr_data = '0;
      tog_rd = 0;
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      @(posedge clk); #1;

      // single 4-word packet
      do_reset();
      rd_ready = 1;
      for (int i = 0; i < 4; i++) wr_word(32'hA0 + i, i == 3);
      repeat (8) tick();

      // back-to-back 3-word and 1-word packets
      do_reset();
      rd_ready = 0;
      for (int i = 0; i < 3; i++) wr_word(32'hB0 + i, i == 2);
      wr_word(32'hB3, 1);
      repeat (2) tick();
      rd_ready = 1;
      repeat (8) tick();

      // abort with a word presented, then a 1-word packet
      do_reset();
      rd_ready = 1;
      wr_word(32'h10, 0);
      wr_word(32'h11, 0);
      wr_valid = 1; wr_data = 32'h12; wr_last = 1; wr_abort = 1;
      tick();
      wr_valid = 0; wr_last = 0; wr_abort = 0;
      wr_word(32'h20, 1);
      repeat (6) tick();

      // full and wrap with toggling consumer
      do_reset();
      rd_ready = 1; tog_rd = 1;
      for (int p = 0; p < 10; p++) begin
         wr_word(32'hC00 + 2 * p, 0);
         wr_word(32'hC01 + 2 * p, 1);
      end
      repeat (20) tick();
      tog_rd = 0;

      // oversize packet with idle consumer, then a normal packet
      do_reset();
      rd_ready = 0; ovf_dut = 0;
      for (int i = 0; i < 6; i++) wr_word(32'hD0 + i, i == 5);
      tick();
      chk("ovf_pulses", ovf_dut, 1);
      chk("ovf_pkt_count", pkt_count, 0);
      wr_word(32'hE0, 0);
      wr_word(32'hE1, 1);
      rd_ready = 1;
      repeat (6) tick();

      // randomized traffic
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         wr_valid = $urandom_range(0, 3) != 0;
         wr_data  = $urandom;
         wr_last  = $urandom_range(0, 2) == 0;
         wr_abort = !drop_m && ((wm - rm) != DEPTH) && ($urandom_range(0, 31) == 0);
         rd_ready = $urandom_range(0, 2) != 0;
         tick();
      end
      wr_valid = 0; wr_abort = 0; wr_last = 0;
      rd_ready = 1;
      repeat (30) tick();

      // reset while a packet is being presented to a stalled consumer
      do_reset();
      rd_ready = 0;
      wr_word(32'h55, 0);
      wr_word(32'h56, 1);
      repeat (3) tick();
      chk("pre_rst_rd_valid", rd_valid, 1);
      do_reset();
      rd_ready = 1;
      repeat (8) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
